blob_frame_tracker: RTL



---
 rtl/blob_pkg.sv | 27 ++
 rtl/blob_coord_counter.sv | 48 ++++
 rtl/blob_frame_tracker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/blob_pkg.sv
// Shared types and defaults for the blob frame tracker.
//   state_t : tracker FSM states
//   bbox_t  : bounding-box accumulator; fields are COORD_W wide so one type
//             serves any X_W/Y_W up to COORD_W. Users zero-extend into it
//             and truncate out of it.
package blob_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam int         H_ACTIVE_DEF = 640;
  localparam int         V_ACTIVE_DEF = 480;
  localparam logic [7:0] THRESH_DEF   = 8'd200;
  localparam int         COORD_W      = 16;

  typedef struct packed {
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
  } bbox_t;

endpackage

// File: rtl/blob_coord_counter.sv
// Raster coordinate counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : restart at (0,0); takes priority over i_adv
//   i_adv          : step to the next pixel (x wraps at H_ACTIVE-1, then y steps)
//   o_x, o_y       : coordinate of the pixel currently presented
//   o_last         : current coordinate is the final pixel of the frame
module blob_coord_counter
  import blob_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clear,
  input  logic           i_adv,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic x_end;
  logic y_end;

  assign x_end  = (o_x == X_W'(H_ACTIVE - 1));
  assign y_end  = (o_y == Y_W'(V_ACTIVE - 1));
  assign o_last = x_end && y_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x <= '0;
      o_y <= '0;
    end else if (i_clear) begin
      o_x <= '0;
      o_y <= '0;
    end else if (i_adv) begin
      if (x_end) begin
        o_x <= '0;
        o_y <= y_end ? '0 : o_y + 1'b1;
      end else begin
        o_x <= o_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blob_frame_tracker.sv
// Frame-level blob detector: scans one grayscale frame after VSYNC while
// i_grayscale_start is high, accumulates a thresholded bounding box and a
// pixel count, and holds the results with o_blob_end high until
// i_grayscale_start drops.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_grayscale_start    : level, high = process frames
//   i_vga_vsync          : frame-boundary strobe
//   i_pix_valid/gray     : pixel stream, meaningful only while scanning
//   o_blob_end           : level, results valid
//   o_blob_found         : count >= MIN_PIXELS
//   o_min/max_x/y, o_cx/cy : bounding box and its centre (zero on empty frame)
//   o_count              : saturating blob pixel count
//   o_trunc              : one-cycle pulse, frame discarded by early VSYNC
module blob_frame_tracker
  import blob_pkg::*;
#(
  parameter int         H_ACTIVE   = H_ACTIVE_DEF,
  parameter int         V_ACTIVE   = V_ACTIVE_DEF,
  parameter int         X_W        = 10,
  parameter int         Y_W        = 10,
  parameter int         CNT_W      = 19,
  parameter logic [7:0] THRESH     = THRESH_DEF,
  parameter int         MIN_PIXELS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_grayscale_start,
  input  logic             i_vga_vsync,
  input  logic             i_pix_valid,
  input  logic [7:0]       i_pix_gray,
  output logic             o_blob_end,
  output logic             o_blob_found,
  output logic [X_W-1:0]   o_min_x,
  output logic [X_W-1:0]   o_max_x,
  output logic [Y_W-1:0]   o_min_y,
  output logic [Y_W-1:0]   o_max_y,
  output logic [X_W-1:0]   o_cx,
  output logic [Y_W-1:0]   o_cy,
  output logic [CNT_W-1:0] o_count,
  output logic             o_trunc
);

  localparam bbox_t BBOX_INIT = '{
    min_x: COORD_W'({X_W{1'b1}}),
    max_x: '0,
    min_y: COORD_W'({Y_W{1'b1}}),
    max_y: '0
  };

  state_t state_reg, state_next;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             last;
  logic             clear_acc, accum_en, load_out, trunc_next;
  bbox_t            bbox_reg, bbox_upd;
  logic [CNT_W-1:0] count_reg, count_upd;
  logic             hit;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  blob_coord_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_coord (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(clear_acc),
    .i_adv  (accum_en),
    .o_x    (x),
    .o_y    (y),
    .o_last (last)
  );

  // Accumulator state including the pixel presented this cycle, so the
  // final pixel is folded into the result on the same edge that loads it.
  always_comb begin
    hit      = i_pix_valid && (i_pix_gray >= THRESH);
    bbox_upd = bbox_reg;
    if (hit) begin
      if (COORD_W'(x) < bbox_reg.min_x) bbox_upd.min_x = COORD_W'(x);
      if (COORD_W'(x) > bbox_reg.max_x) bbox_upd.max_x = COORD_W'(x);
      if (COORD_W'(y) < bbox_reg.min_y) bbox_upd.min_y = COORD_W'(y);
      if (COORD_W'(y) > bbox_reg.max_y) bbox_upd.max_y = COORD_W'(y);
    end
    count_upd = (hit && (count_reg != '1)) ? count_reg + 1'b1 : count_reg;
    sum_x = {1'b0, bbox_upd.min_x[X_W-1:0]} + {1'b0, bbox_upd.max_x[X_W-1:0]};
    sum_y = {1'b0, bbox_upd.min_y[Y_W-1:0]} + {1'b0, bbox_upd.max_y[Y_W-1:0]};
  end

  // Next state and control. In S_ACCUM: abort beats everything, then the
  // final pixel beats a coincident VSYNC, then an early VSYNC restarts.
  always_comb begin
    state_next = state_reg;
    clear_acc  = 1'b0;
    accum_en   = 1'b0;
    load_out   = 1'b0;
    trunc_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_grayscale_start) state_next = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!i_grayscale_start) begin
          state_next = S_IDLE;
        end else if (i_vga_vsync) begin
          state_next = S_ACCUM;
          clear_acc  = 1'b1;
        end
      end
      S_ACCUM: begin
        if (!i_grayscale_start) begin
          state_next = S_IDLE;
        end else if (i_pix_valid && last) begin
          state_next = S_DONE;
          load_out   = 1'b1;
          accum_en   = 1'b1;
        end else if (i_vga_vsync) begin
          clear_acc  = 1'b1;
          trunc_next = 1'b1;
        end else if (i_pix_valid) begin
          accum_en   = 1'b1;
        end
      end
      S_DONE: begin
        if (!i_grayscale_start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      bbox_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clear_acc) begin
        bbox_reg  <= BBOX_INIT;
        count_reg <= '0;
      end else if (accum_en) begin
        bbox_reg  <= bbox_upd;
        count_reg <= count_upd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_blob_end   <= 1'b0;
      o_trunc      <= 1'b0;
      o_blob_found <= 1'b0;
      o_min_x      <= '0;
      o_max_x      <= '0;
      o_min_y      <= '0;
      o_max_y      <= '0;
      o_cx         <= '0;
      o_cy         <= '0;
      o_count      <= '0;
    end else begin
      o_blob_end <= (state_next == S_DONE);
      o_trunc    <= trunc_next;
      if (load_out) begin
        o_count <= count_upd;
        if (count_upd == '0) begin
          // Empty frame: the sentinel min/max values are meaningless.
          o_blob_found <= 1'b0;
          o_min_x      <= '0;
          o_max_x      <= '0;
          o_min_y      <= '0;
          o_max_y      <= '0;
          o_cx         <= '0;
          o_cy         <= '0;
        end else begin
          o_blob_found <= (count_upd >= CNT_W'(MIN_PIXELS));
          o_min_x      <= bbox_upd.min_x[X_W-1:0];
          o_max_x      <= bbox_upd.max_x[X_W-1:0];
          o_min_y      <= bbox_upd.min_y[Y_W-1:0];
          o_max_y      <= bbox_upd.max_y[Y_W-1:0];
          o_cx         <= sum_x[X_W:1];
          o_cy         <= sum_y[Y_W:1];
        end
      end
    end
  end

endmodule
